// File: rtl/shifter_iter.sv
// Multi-cycle shift/rotate unit: one barrel stage (1, 2, 4, 8) applied per clock
// to a registered working value, with a start/busy/done handshake.

module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

// One fixed-distance stage. Wrapped bits feed the fill positions for rotates;
// shifts substitute zero there.
module shift_stage #(
  parameter int N = 1
) (
  input  logic [15:0] d,
  input  logic        right,
  input  logic        shift,
  output logic [15:0] q
);
  genvar i;
  for (i = 0; i < 16; i++) begin : g_bit
    logic left_bit;
    logic right_bit;

    if (i >= N) begin : g_left
      assign left_bit = d[i-N];
    end else begin : g_left_fill
      mux2_1 u_fill (.a(d[i-N+16]), .b(1'b0), .sel(shift), .y(left_bit));
    end

    if (i + N < 16) begin : g_right
      assign right_bit = d[i+N];
    end else begin : g_right_fill
      mux2_1 u_fill (.a(d[i+N-16]), .b(1'b0), .sel(shift), .y(right_bit));
    end

    mux2_1 u_dir (.a(left_bit), .b(right_bit), .sel(right), .y(q[i]));
  end
endmodule

module shifter_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  input  logic [1:0]  Op,
  output logic [15:0] Out,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic [2:0] {IDLE, ST1, ST2, ST4, ST8, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] work;
  logic [3:0]  cnt_r;
  logic [1:0]  op_r;
  logic [15:0] s1, s2, s4, s8;
  logic        accept;

  // Op[1] selects direction, Op[0] selects logical shift over rotate.
  shift_stage #(.N(1)) u_s1 (.d(work), .right(op_r[1]), .shift(op_r[0]), .q(s1));
  shift_stage #(.N(2)) u_s2 (.d(work), .right(op_r[1]), .shift(op_r[0]), .q(s2));
  shift_stage #(.N(4)) u_s4 (.d(work), .right(op_r[1]), .shift(op_r[0]), .q(s4));
  shift_stage #(.N(8)) u_s8 (.d(work), .right(op_r[1]), .shift(op_r[0]), .q(s8));

  assign accept = Start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = Start ? ST1 : IDLE;
      ST1:     state_nxt = ST2;
      ST2:     state_nxt = ST4;
      ST4:     state_nxt = ST8;
      ST8:     state_nxt = DONE;
      DONE:    state_nxt = Start ? ST1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operands are captured on accept; each busy state then folds in one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work  <= 16'h0000;
      cnt_r <= 4'h0;
      op_r  <= 2'b00;
      Out   <= 16'h0000;
    end else if (accept) begin
      work  <= In;
      cnt_r <= Cnt;
      op_r  <= Op;
    end else begin
      case (state)
        ST1:     work <= cnt_r[0] ? s1 : work;
        ST2:     work <= cnt_r[1] ? s2 : work;
        ST4:     work <= cnt_r[2] ? s4 : work;
        ST8:     Out  <= cnt_r[3] ? s8 : work;
        default: ;
      endcase
    end
  end

  assign Busy = (state == ST1) || (state == ST2) || (state == ST4) || (state == ST8);
  assign Done = (state == DONE);
endmodule

// File: tb/tb_shifter_iter.sv
// Bench for shifter_iter: directed cases from hand-computed values plus random
// traffic checked every cycle against a bit-at-a-time reference model.

module tb_shifter_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in_v = 16'h0000;
  logic [3:0]  cnt = 4'h0;
  logic [1:0]  op = 2'b00;
  logic [15:0] out_v;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail = 0;

  // Model: age = cycles since acceptance (0 idle, 1..4 busy, 5 done).
  int          age = 0;
  logic [15:0] pend = 16'h0000;
  logic [15:0] exp_out = 16'h0000;

  shifter_iter dut (
    .clk(clk), .rst(rst), .Start(start), .In(in_v), .Cnt(cnt), .Op(op),
    .Out(out_v), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_op(input logic [15:0] x, input int c, input logic [1:0] o);
    logic [15:0] r;
    r = x;
    for (int k = 0; k < c; k++) begin
      case (o)
        2'b00: r = {r[14:0], r[15]};
        2'b01: r = {r[14:0], 1'b0};
        2'b10: r = {r[0], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = 0;
      exp_out = 16'h0000;
      pend = 16'h0000;
    end else if (age >= 1 && age <= 4) begin
      age = age + 1;
      if (age == 5) exp_out = pend;
    end else if (start) begin
      pend = ref_op(in_v, int'(cnt), op);
      age = 1;
    end else begin
      age = 0;
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, (age >= 1 && age <= 4)});
    chk("done", {31'd0, done}, {31'd0, (age == 5)});
    chk("out", {16'd0, out_v}, {16'd0, exp_out});
  end

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no Done within 12 cycles, required a Done pulse", name);
    end
  endtask

  task automatic do_op(input string name, input logic [15:0] x, input logic [3:0] c,
                       input logic [1:0] o, input logic [15:0] expv);
    bit ok;
    @(posedge clk); #1;
    start = 1'b1; in_v = x; cnt = c; op = o;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(name, ok);
    if (ok) chk(name, {16'd0, out_v}, {16'd0, expv});
  endtask

  initial begin : main
    int          done_cnt;
    logic [15:0] outs[$];
    int          times[$];

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {16'd0, out_v}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    chk("reset_done", {31'd0, done}, 32'h0);
    rst = 1'b0;

    do_op("rotl_1234_4", 16'h1234, 4'd4, 2'b00, 16'h2341);
    repeat (3) @(negedge clk);
    chk("rotl_hold", {16'd0, out_v}, 32'h2341);
    do_op("shl_8001_15", 16'h8001, 4'd15, 2'b01, 16'h8000);
    do_op("shr_8000_15", 16'h8000, 4'd15, 2'b11, 16'h0001);
    do_op("rotr_1234_4", 16'h1234, 4'd4, 2'b10, 16'h4123);
    do_op("rotr_cnt0", 16'hA5C3, 4'd0, 2'b10, 16'hA5C3);
    do_op("rotl_0001_15", 16'h0001, 4'd15, 2'b00, 16'h8000);

    // Start while busy must be ignored.
    @(posedge clk); #1;
    start = 1'b1; in_v = 16'h00FF; cnt = 4'd8; op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_v = 16'hFFFF;
    end
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("busy_ignore_dones", done_cnt, 1);
    chk("busy_ignore_out", {16'd0, out_v}, 32'hFF00);

    // Back-to-back with Start held high.
    fork
      begin
        @(posedge clk); #1;
        start = 1'b1; in_v = 16'h0001; op = 2'b01; cnt = 4'd1;
        @(posedge clk); #1;
        cnt = 4'd2;
        repeat (5) @(posedge clk);
        #1 cnt = 4'd3;
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
      end
      begin
        for (int i = 0; i < 25; i++) begin
          @(negedge clk);
          if (done) begin
            outs.push_back(out_v);
            times.push_back(i);
          end
        end
      end
    join
    chk("b2b_count", outs.size(), 3);
    if (outs.size() == 3) begin
      chk("b2b_out0", {16'd0, outs[0]}, 32'h0002);
      chk("b2b_out1", {16'd0, outs[1]}, 32'h0004);
      chk("b2b_out2", {16'd0, outs[2]}, 32'h0008);
      chk("b2b_gap0", times[1] - times[0], 5);
      chk("b2b_gap1", times[2] - times[1], 5);
    end

    // Asynchronous reset while in ST4.
    @(posedge clk); #1;
    start = 1'b1; in_v = 16'h1234; cnt = 4'd4; op = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", {16'd0, out_v}, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'h0);
    chk("arst_done", {31'd0, done}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op("after_arst", 16'h00F0, 4'd4, 2'b11, 16'h000F);

    // Random traffic, checked every cycle by the compare process.
    for (int i = 0; i < 900; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      in_v  = 16'($urandom);
      cnt   = 4'($urandom);
      op    = 2'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units, required completion");
    $fatal(1, "timeout");
  end
endmodule
